// File: rtl/sdram_init_seq.sv
// SDR SDRAM power-up initialisation sequencer and refresh-request timer.
//
// After reset it walks the SDRAM through: NOP wait, PRECHARGE ALL, REFRESH_COUNT x AUTO REFRESH,
// LOAD MODE REGISTER, then raises init_done (sticky until reset). From then on the command pins
// idle at NOP and a periodic refresh request is raised towards the controller.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   sdram_cke     SDRAM clock enable (low only while in reset)
//   sdram_cs_n    chip select; command is {cs_n, ras_n, cas_n, we_n}
//   sdram_ras_n   RAS
//   sdram_cas_n   CAS
//   sdram_we_n    WE
//   sdram_a       address / mode bits (A10 for PRECHARGE ALL, MODE_REG for LOAD MODE)
//   sdram_ba      bank address, always 0
//   sdram_dqm     {DQMH, DQML}; held high until the sequence completes
//   init_done     sequence complete, sticky until reset
//   refresh_req   controller must issue one AUTO REFRESH
//   refresh_ack   controller has issued the requested refresh
//   refresh_miss  sticky; an interval expired while a request was still pending
module sdram_init_seq #(
   parameter int unsigned WAIT_CYCLES      = 5000,
   parameter int unsigned T_RP             = 2,
   parameter int unsigned T_RFC            = 3,
   parameter int unsigned REFRESH_COUNT    = 8,
   parameter int unsigned T_MRD            = 2,
   parameter logic [12:0] MODE_REG         = 13'h020,
   parameter int unsigned REFRESH_INTERVAL = 195
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        sdram_cke,
   output logic        sdram_cs_n,
   output logic        sdram_ras_n,
   output logic        sdram_cas_n,
   output logic        sdram_we_n,
   output logic [12:0] sdram_a,
   output logic [1:0]  sdram_ba,
   output logic [1:0]  sdram_dqm,
   output logic        init_done,
   output logic        refresh_req,
   input  logic        refresh_ack,
   output logic        refresh_miss
);

   // Command encodings {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CmdDesel = 4'b1111;
   localparam logic [3:0] CmdNop   = 4'b0111;
   localparam logic [3:0] CmdPre   = 4'b0010;
   localparam logic [3:0] CmdRef   = 4'b0001;
   localparam logic [3:0] CmdLmr   = 4'b0000;

   // Each delay counter counts down to zero; the command cycle itself is the first cycle of the
   // spacing, so a spacing of 1 goes straight to the next command without visiting the wait state.
   localparam logic [15:0] WaitLoad = 16'(WAIT_CYCLES - 1);
   localparam logic [15:0] TrpLoad  = 16'(T_RP - 1);
   localparam logic [15:0] TrfcLoad = 16'(T_RFC - 1);
   localparam logic [15:0] TmrdLoad = 16'(T_MRD - 1);
   localparam logic [3:0]  RefTotal = 4'(REFRESH_COUNT);
   localparam logic [15:0] Interval = 16'(REFRESH_INTERVAL);

   typedef enum logic [3:0] {
      StReset,
      StWait,
      StPre,
      StTrp,
      StRef,
      StTrfc,
      StLmr,
      StTmrd,
      StDone
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] dly_q, dly_d;
   logic [3:0]  ref_q, ref_d;
   logic [15:0] int_q, int_d;
   logic        req_q, req_d;
   logic        miss_q, miss_d;

   logic [3:0]  cmd_q, cmd_d;
   logic [12:0] a_q, a_d;
   logic        cke_q, cke_d;
   logic [1:0]  dqm_q, dqm_d;
   logic        done_q, done_d;

   // Next-state logic for the init sequence
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      ref_d   = ref_q;
      unique case (state_q)
         StReset: begin
            state_d = StWait;
            dly_d   = WaitLoad;
         end
         StWait: begin
            if (dly_q == '0) begin
               state_d = StPre;
               dly_d   = TrpLoad;
            end else begin
               dly_d = dly_q - 16'd1;
            end
         end
         StPre, StTrp: begin
            if (dly_q == '0) begin
               state_d = StRef;
               dly_d   = TrfcLoad;
               ref_d   = ref_q + 4'd1;
            end else begin
               state_d = StTrp;
               dly_d   = dly_q - 16'd1;
            end
         end
         StRef, StTrfc: begin
            if (dly_q == '0) begin
               if (ref_q < RefTotal) begin
                  state_d = StRef;
                  dly_d   = TrfcLoad;
                  ref_d   = ref_q + 4'd1;
               end else begin
                  state_d = StLmr;
                  dly_d   = TmrdLoad;
               end
            end else begin
               state_d = StTrfc;
               dly_d   = dly_q - 16'd1;
            end
         end
         StLmr, StTmrd: begin
            if (dly_q == '0) begin
               state_d = StDone;
            end else begin
               state_d = StTmrd;
               dly_d   = dly_q - 16'd1;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StReset;
         end
      endcase
   end

   // Pin values are decoded from the next state so every output comes straight from a flop
   // and the command appears in the cycle the state is entered.
   always_comb begin
      cmd_d  = CmdNop;
      a_d    = '0;
      cke_d  = 1'b1;
      dqm_d  = 2'b11;
      done_d = 1'b0;
      unique case (state_d)
         StReset: begin
            cmd_d = CmdDesel;
            cke_d = 1'b0;
         end
         StPre: begin
            cmd_d     = CmdPre;
            a_d[10]   = 1'b1;
         end
         StRef: begin
            cmd_d = CmdRef;
         end
         StLmr: begin
            cmd_d = CmdLmr;
            a_d   = MODE_REG;
         end
         StDone: begin
            dqm_d  = 2'b00;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Refresh interval timer and req/ack handshake, active only once in DONE
   always_comb begin
      int_d  = '0;
      req_d  = req_q;
      miss_d = miss_q;
      if (state_q == StDone) begin
         if (req_q && refresh_ack) begin
            req_d = 1'b0;
            int_d = '0;
         end else if (int_q + 16'd1 == Interval) begin
            // Expiry with a request still outstanding: flag it and keep the request raised
            if (req_q) begin
               miss_d = 1'b1;
            end
            req_d = 1'b1;
            int_d = '0;
         end else begin
            int_d = int_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StReset;
         dly_q   <= '0;
         ref_q   <= '0;
         int_q   <= '0;
         req_q   <= 1'b0;
         miss_q  <= 1'b0;
         cmd_q   <= CmdDesel;
         a_q     <= '0;
         cke_q   <= 1'b0;
         dqm_q   <= 2'b11;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         ref_q   <= ref_d;
         int_q   <= int_d;
         req_q   <= req_d;
         miss_q  <= miss_d;
         cmd_q   <= cmd_d;
         a_q     <= a_d;
         cke_q   <= cke_d;
         dqm_q   <= dqm_d;
         done_q  <= done_d;
      end
   end

   assign sdram_cke    = cke_q;
   assign sdram_cs_n   = cmd_q[3];
   assign sdram_ras_n  = cmd_q[2];
   assign sdram_cas_n  = cmd_q[1];
   assign sdram_we_n   = cmd_q[0];
   assign sdram_a      = a_q;
   assign sdram_ba     = 2'b00;
   assign sdram_dqm    = dqm_q;
   assign init_done    = done_q;
   assign refresh_req  = req_q;
   assign refresh_miss = miss_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Self-checking bench for sdram_init_seq: a default-parameter instance for the full power-up
// schedule, reset behaviour and refresh handshake, and a short-timing instance for the
// minimum-spacing corner.
module tb_sdram_init_seq;

   localparam int W    = 5000;
   localparam int TRP  = 2;
   localparam int TRFC = 3;
   localparam int RC   = 8;
   localparam int TMRD = 2;
   localparam int RI   = 195;
   localparam int P    = W;
   localparam int L    = P + TRP + RC * TRFC;
   localparam int D    = L + TMRD;
   localparam int LOG_LEN = 5100;
   localparam int S_LEN   = 20;

   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] REF = 4'b0001;
   localparam logic [3:0] LMR = 4'b0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, ack, ack_s;
   logic        cke, cs_n, ras_n, cas_n, we_n, done, req, miss;
   logic [12:0] a;
   logic [1:0]  ba, dqm;
   logic        cke_s, cs_n_s, ras_n_s, cas_n_s, we_n_s, done_s, req_s, miss_s;
   logic [12:0] a_s;
   logic [1:0]  ba_s, dqm_s;
   logic [3:0]  cmd, cmd_s;

   assign cmd   = {cs_n, ras_n, cas_n, we_n};
   assign cmd_s = {cs_n_s, ras_n_s, cas_n_s, we_n_s};

   sdram_init_seq #(
      .WAIT_CYCLES(W), .T_RP(TRP), .T_RFC(TRFC), .REFRESH_COUNT(RC), .T_MRD(TMRD),
      .MODE_REG(13'h020), .REFRESH_INTERVAL(RI)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
      .sdram_cas_n(cas_n), .sdram_we_n(we_n), .sdram_a(a), .sdram_ba(ba), .sdram_dqm(dqm),
      .init_done(done), .refresh_req(req), .refresh_ack(ack), .refresh_miss(miss)
   );

   sdram_init_seq #(
      .WAIT_CYCLES(4), .T_RP(1), .T_RFC(1), .REFRESH_COUNT(1), .T_MRD(1),
      .MODE_REG(13'h020), .REFRESH_INTERVAL(4)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .sdram_cke(cke_s), .sdram_cs_n(cs_n_s), .sdram_ras_n(ras_n_s),
      .sdram_cas_n(cas_n_s), .sdram_we_n(we_n_s), .sdram_a(a_s), .sdram_ba(ba_s),
      .sdram_dqm(dqm_s), .init_done(done_s), .refresh_req(req_s), .refresh_ack(ack_s),
      .refresh_miss(miss_s)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [3:0]  cmd_log [LOG_LEN];
   logic [12:0] a_log   [LOG_LEN];
   logic        done_log[LOG_LEN];
   logic        cke_log [LOG_LEN];
   logic [1:0]  dqm_log [LOG_LEN];
   logic [1:0]  ba_log  [LOG_LEN];
   logic [3:0]  cmd_s_log [S_LEN];
   logic [12:0] a_s_log   [S_LEN];
   logic        done_s_log[S_LEN];
   logic        req_s_log [S_LEN];
   logic        miss_s_log[S_LEN];

   typedef struct {
      bit          sel;   // 0: default instance, 1: short-timing instance
      int          cyc;
      logic [3:0]  cmd;
      logic [12:0] a;
      logic        done;
   } vec_t;

   vec_t vt[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Advance to just after the next rising edge; cyc then names the cycle being observed.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_cke"},  32'(cke),   32'd0);
      check({tag, "_cmd"},  32'(cmd),   32'hF);
      check({tag, "_a"},    32'(a),     32'd0);
      check({tag, "_ba"},   32'(ba),    32'd0);
      check({tag, "_dqm"},  32'(dqm),   32'd3);
      check({tag, "_done"}, 32'(done),  32'd0);
      check({tag, "_req"},  32'(req),   32'd0);
      check({tag, "_miss"}, 32'(miss),  32'd0);
   endtask

   task automatic wait_req(output int rise, input int budget);
      rise = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (req) begin
            rise = cyc;
            break;
         end
      end
   endtask

   initial begin : main
      int r, nxt, width, bad, n_pre, n_ref, n_lmr;
      int first_pre, first_done, first_req, first_miss, drops;
      logic [3:0]  ec;
      logic [12:0] ea;

      rst_n = 1'b0;
      ack   = 1'b0;
      ack_s = 1'b1;   // held high throughout: must be ignored until the short instance is done

      // Reset held for 10 cycles
      for (int i = 0; i < 10; i++) tick();
      check_reset("por");
      check("por_s_cke", 32'(cke_s), 32'd0);

      // Release; the next edge is E0
      rst_n = 1'b1;
      cyc   = -1;
      for (int i = 0; i < LOG_LEN; i++) begin
         tick();
         cmd_log[cyc]  = cmd;
         a_log[cyc]    = a;
         done_log[cyc] = done;
         cke_log[cyc]  = cke;
         dqm_log[cyc]  = dqm;
         ba_log[cyc]   = ba;
         if (cyc < S_LEN) begin
            cmd_s_log[cyc]  = cmd_s;
            a_s_log[cyc]    = a_s;
            done_s_log[cyc] = done_s;
            req_s_log[cyc]  = req_s;
            miss_s_log[cyc] = miss_s;
         end
      end

      // Directed schedule vectors
      vt.push_back('{1'b0, 0,    NOP, 13'h000, 1'b0});
      vt.push_back('{1'b0, 4999, NOP, 13'h000, 1'b0});
      vt.push_back('{1'b0, 5000, PRE, 13'h400, 1'b0});
      vt.push_back('{1'b0, 5001, NOP, 13'h000, 1'b0});
      vt.push_back('{1'b0, 5002, REF, 13'h000, 1'b0});
      vt.push_back('{1'b0, 5005, REF, 13'h000, 1'b0});
      vt.push_back('{1'b0, 5023, REF, 13'h000, 1'b0});
      vt.push_back('{1'b0, 5024, NOP, 13'h000, 1'b0});
      vt.push_back('{1'b0, 5026, LMR, 13'h020, 1'b0});
      vt.push_back('{1'b0, 5027, NOP, 13'h000, 1'b0});
      vt.push_back('{1'b0, 5028, NOP, 13'h000, 1'b1});
      vt.push_back('{1'b1, 3,    NOP, 13'h000, 1'b0});
      vt.push_back('{1'b1, 4,    PRE, 13'h400, 1'b0});
      vt.push_back('{1'b1, 5,    REF, 13'h000, 1'b0});
      vt.push_back('{1'b1, 6,    LMR, 13'h020, 1'b0});
      vt.push_back('{1'b1, 7,    NOP, 13'h000, 1'b1});

      foreach (vt[i]) begin
         if (vt[i].sel) begin
            check($sformatf("vec%0d_s_cmd@%0d", i, vt[i].cyc), 32'(cmd_s_log[vt[i].cyc]),
                  32'(vt[i].cmd));
            check($sformatf("vec%0d_s_a@%0d", i, vt[i].cyc), 32'(a_s_log[vt[i].cyc]),
                  32'(vt[i].a));
            check($sformatf("vec%0d_s_done@%0d", i, vt[i].cyc), 32'(done_s_log[vt[i].cyc]),
                  32'(vt[i].done));
         end else begin
            check($sformatf("vec%0d_cmd@%0d", i, vt[i].cyc), 32'(cmd_log[vt[i].cyc]),
                  32'(vt[i].cmd));
            check($sformatf("vec%0d_a@%0d", i, vt[i].cyc), 32'(a_log[vt[i].cyc]),
                  32'(vt[i].a));
            check($sformatf("vec%0d_done@%0d", i, vt[i].cyc), 32'(done_log[vt[i].cyc]),
                  32'(vt[i].done));
         end
      end
      check("cke_after_release", 32'(cke_log[0]), 32'd1);

      // Every logged cycle against a schedule model
      bad = 0; n_pre = 0; n_ref = 0; n_lmr = 0;
      for (int n = 0; n < LOG_LEN; n++) begin
         ec = NOP;
         ea = 13'h000;
         if (n == P) begin
            ec = PRE; ea = 13'h400;
         end else if (n >= P + TRP && n < L && ((n - P - TRP) % TRFC) == 0) begin
            ec = REF;
         end else if (n == L) begin
            ec = LMR; ea = 13'h020;
         end
         if (cmd_log[n] !== ec || a_log[n] !== ea || done_log[n] !== (n >= D) ||
             cke_log[n] !== 1'b1 || ba_log[n] !== 2'b00 ||
             dqm_log[n] !== ((n >= D) ? 2'b00 : 2'b11)) bad++;
         if (cmd_log[n] === PRE) n_pre++;
         if (cmd_log[n] === REF) n_ref++;
         if (cmd_log[n] === LMR) n_lmr++;
      end
      check("sweep_bad_cycles", 32'(bad), 32'd0);
      check("count_precharge", 32'(n_pre), 32'd1);
      check("count_refresh", 32'(n_ref), 32'(RC));
      check("count_loadmode", 32'(n_lmr), 32'd1);

      // Short instance with ack held high: ignored before DONE, then a 1-cycle request
      check("s_req_before", 32'(req_s_log[10]), 32'd0);
      check("s_req_rise", 32'(req_s_log[11]), 32'd1);
      check("s_req_drop", 32'(req_s_log[12]), 32'd0);
      check("s_req_again15", 32'(req_s_log[15]), 32'd0);
      check("s_req_again16", 32'(req_s_log[16]), 32'd1);
      check("s_miss", 32'(miss_s_log[19]), 32'd0);

      // Handshake: ack is sampled on the third edge after the rise edge, so the request is high
      // for 3 cycles and the next rise follows RI cycles after the ack edge.
      wait_req(r, 400);
      check("req_first_rise", 32'(r), 32'(D + RI));
      for (int k = 0; k < 3; k++) begin
         width = 1;
         tick(); if (req) width++;
         tick(); if (req) width++;
         ack = 1'b1;
         tick();
         ack = 1'b0;
         check($sformatf("req_drop_%0d", k), 32'(req), 32'd0);
         check($sformatf("req_width_%0d", k), 32'(width), 32'd3);
         wait_req(nxt, 400);
         check($sformatf("req_spacing_%0d", k), 32'(nxt - r), 32'(3 + RI));
         r = nxt;
      end
      check("miss_with_acks", 32'(miss), 32'd0);

      // Fresh sequence, then reset asserted mid-refresh at cycle 5010, released at 5015
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      cyc   = -1;
      while (cyc < 5010) tick();
      rst_n = 1'b0;
      tick();
      check_reset("midrst");
      while (cyc < 5015) tick();
      check("midrst_hold_cke", 32'(cke), 32'd0);
      rst_n = 1'b1;
      cyc   = -1;
      first_pre  = -1;
      first_done = -1;
      while (cyc < D) begin
         tick();
         if (cmd === PRE && first_pre < 0) first_pre = cyc;
         if (done === 1'b1 && first_done < 0) first_done = cyc;
      end
      check("restart_precharge", 32'(first_pre), 32'(P));
      check("restart_done", 32'(first_done), 32'(D));

      // Never ack: the request stays up and the second expiry flags a miss
      first_req  = -1;
      first_miss = -1;
      drops      = 0;
      while (cyc < D + 2 * RI) begin
         tick();
         if (req === 1'b1 && first_req < 0) first_req = cyc;
         if (first_req >= 0 && req !== 1'b1) drops++;
         if (miss === 1'b1 && first_miss < 0) first_miss = cyc;
      end
      check("noack_req_rise", 32'(first_req), 32'(D + RI));
      check("noack_req_held", 32'(drops), 32'd0);
      check("noack_miss_cycle", 32'(first_miss), 32'(D + 2 * RI));
      tick();
      tick();
      check("noack_req_still", 32'(req), 32'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("late_ack_drop", 32'(req), 32'd0);
      tick();
      tick();
      check("miss_sticky", 32'(miss), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
